// File: rtl/wdt_reset_req.sv
// Watchdog timer on the picorv32 native bus; emits an active-low reset request pulse on a missed kick.
// Bus: mem_ready one cycle after mem_valid is accepted; bite: wdt_reset_n falls LOAD+1 edges after enable.
// No backpressure: accesses are acked every other cycle at most; writes during a bite are acked but inert.
module wdt_reset_req #(
  parameter int unsigned PULSE_CYCLES = 16,
  parameter logic [31:0] KICK_KEY     = 32'h5A5A_5A5A,
  parameter logic [31:0] LOAD_RESET   = 32'd27_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [3:0]  mem_addr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        wdt_reset_n
);

  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIRE} state_t;

  state_t         state_q, state_d;
  logic [31:0]    load_q;
  logic [31:0]    count_q;
  logic           cause_q;
  logic [PW-1:0]  pcnt_q;
  logic           cnt_load, cnt_dec;
  logic [31:0]    rd_mux;

  // Byte-offset bits are not decoded; the bus is word addressed.
  logic unused_addr;
  assign unused_addr = &{1'b0, mem_addr[1:0]};

  // A request is taken only when no ack is in flight, giving ready every other cycle back-to-back.
  logic       acc;
  logic [1:0] sel;
  logic       ctrl_wr, en_set, en_clr, kick_ok;

  assign acc     = mem_valid && !mem_ready;
  assign sel     = mem_addr[3:2];
  assign ctrl_wr = acc && (sel == 2'd0) && mem_wstrb[0];
  assign en_set  = ctrl_wr && mem_wdata[0];
  assign en_clr  = ctrl_wr && !mem_wdata[0];
  assign kick_ok = acc && (sel == 2'd2) && (mem_wstrb == 4'hF) && (mem_wdata == KICK_KEY);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and counter controls; a kick beats an expiring count, an expiry beats a disable.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_set) begin
          state_d  = RUN;
          cnt_load = 1'b1;
        end else if (kick_ok) begin
          cnt_load = 1'b1;
        end
      end
      RUN: begin
        if (kick_ok) begin
          cnt_load = 1'b1;
        end else if (count_q == 32'd0) begin
          state_d = FIRE;
        end else if (en_clr) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      FIRE: begin
        if (pcnt_q == PLAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter: reload on enable/kick, saturating decrement while running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      count_q <= LOAD_RESET;
    else if (cnt_load) count_q <= load_q;
    else if (cnt_dec)  count_q <= count_q - 32'd1;
  end

  // Reload register with per-byte strobes; it only reaches COUNT at the next kick or enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_q <= LOAD_RESET;
    end else if (acc && (sel == 2'd1)) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) load_q[8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Sticky bite cause: set on entry to FIRE (wins over a same-cycle clear), cleared by writing 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                     cause_q <= 1'b0;
    else if (state_q == RUN && state_d == FIRE)       cause_q <= 1'b1;
    else if (ctrl_wr && mem_wdata[1])                 cause_q <= 1'b0;
  end

  // Pulse-width counter: counts cycles spent in FIRE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               pcnt_q <= '0;
    else if (state_q != FIRE)   pcnt_q <= '0;
    else                        pcnt_q <= pcnt_q + 1'b1;
  end

  // Registered, glitch-free reset request, low exactly while the next state is FIRE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wdt_reset_n <= 1'b1;
    else          wdt_reset_n <= (state_d != FIRE);
  end

  // Read mux over pre-update register contents; EN is simply "running".
  always_comb begin
    rd_mux = 32'd0;
    unique case (sel)
      2'd0:    rd_mux = {30'd0, cause_q, (state_q == RUN)};
      2'd1:    rd_mux = load_q;
      2'd2:    rd_mux = 32'd0;
      2'd3:    rd_mux = count_q;
      default: rd_mux = 32'd0;
    endcase
  end

  // One-cycle ack with read data; data is zero whenever ready is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_ready <= 1'b0;
      mem_rdata <= 32'd0;
    end else begin
      mem_ready <= acc;
      mem_rdata <= acc ? rd_mux : 32'd0;
    end
  end

endmodule

// File: tb/tb_wdt_reset_req.sv
module tb_wdt_reset_req;

  localparam logic [31:0] KEY = 32'h5A5A_5A5A;
  localparam int PULSE = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [3:0]  mem_addr = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        wdt_reset_n;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  wdt_reset_req #(
    .PULSE_CYCLES(PULSE),
    .KICK_KEY(KEY),
    .LOAD_RESET(32'd8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .wdt_reset_n(wdt_reset_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One bus access from a negedge; returns read data and the ack edge index, checks ready is a single pulse.
  task automatic bus_xfer(input logic [3:0] a, input logic [3:0] s, input logic [31:0] d,
                          output logic [31:0] rd, output int ack);
    bit got;
    got = 0; rd = '0; ack = -1;
    mem_valid = 1'b1; mem_addr = a; mem_wstrb = s; mem_wdata = d;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (mem_ready === 1'b1) begin
        got = 1; rd = mem_rdata; ack = cyc;
      end
    end
    mem_valid = 1'b0; mem_wstrb = '0;
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL bus_ack addr=%0h: ready never seen, required within 8 cycles", a);
    end else begin
      @(negedge clk);
      tests++;
      if (mem_ready !== 1'b0 || mem_rdata !== 32'd0) begin
        fails++;
        $display("FAIL ready_pulse addr=%0h: ready=%b rdata=%h, required ready=0 rdata=0", a, mem_ready, mem_rdata);
      end
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, output int ack);
    logic [31:0] rd;
    bus_xfer(a, s, d, rd, ack);
  endtask

  // Scoreboard read: expectation queued at issue, popped and compared on ack.
  task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] rd, e;
    string n;
    int ack;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    bus_xfer(a, 4'h0, 32'd0, rd, ack);
    e = exp_q.pop_front();
    n = name_q.pop_front();
    tests++;
    if (rd !== e) begin
      fails++;
      $display("FAIL %s: got %h, required %h", n, rd, e);
    end
  endtask

  // Watch for one bite after ack edge e; check fall offset and low width.
  task automatic wait_bite(input int e, input int fall_off, input string nm);
    int fall_c, rise_c;
    fall_c = -1; rise_c = -1;
    for (int i = 0; i < 200 && rise_c < 0; i++) begin
      if (fall_c < 0 && wdt_reset_n === 1'b0) fall_c = cyc;
      else if (fall_c >= 0 && wdt_reset_n === 1'b1) rise_c = cyc;
      if (rise_c < 0) @(negedge clk);
    end
    tests++;
    if (fall_c < 0 || fall_c - e != fall_off) begin
      fails++;
      $display("FAIL %s_fall: offset %0d, required %0d", nm, fall_c - e, fall_off);
    end
    tests++;
    if (rise_c < 0 || rise_c - fall_c != PULSE) begin
      fails++;
      $display("FAIL %s_width: %0d cycles, required %0d", nm, rise_c - fall_c, PULSE);
    end
  endtask

  task automatic test_reset();
    tests++;
    if (wdt_reset_n !== 1'b1 || mem_ready !== 1'b0 || mem_rdata !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs: wdt=%b ready=%b rdata=%h, required 1 0 0", wdt_reset_n, mem_ready, mem_rdata);
    end
    bus_read(4'h0, 32'd0, "reset_ctrl");
    bus_read(4'h4, 32'd8, "reset_load");
    bus_read(4'h8, 32'd0, "reset_kick");
    bus_read(4'hC, 32'd8, "reset_count");
  endtask

  task automatic test_bite();
    int ack;
    bus_write(4'h4, 32'd5, 4'hF, ack);
    bus_write(4'h0, 32'd1, 4'h1, ack);
    wait_bite(ack, 6, "bite5");
    bus_read(4'h0, 32'd2, "bite5_cause");
    bus_write(4'h0, 32'd2, 4'h1, ack);
    bus_read(4'h0, 32'd0, "bite5_cause_clr");
  endtask

  task automatic test_kick();
    int ack, k, bad_wdt;
    bad_wdt = 0;
    bus_write(4'h4, 32'd20, 4'hF, ack);
    bus_write(4'h0, 32'd1, 4'h1, ack);
    for (int n = 0; n < 16; n++) begin
      bus_write(4'h8, KEY, 4'hF, k);
      bus_read(4'hC, 32'd19, "kick_count");
      while (cyc < k + 10) begin
        if (wdt_reset_n !== 1'b1) bad_wdt++;
        @(negedge clk);
      end
    end
    tests++;
    if (bad_wdt != 0) begin
      fails++;
      $display("FAIL kick_no_bite: %0d low samples, required 0", bad_wdt);
    end
    bus_read(4'h0, 32'd1, "kick_ctrl_running");
    bus_write(4'h0, 32'd0, 4'h1, ack);
    bus_read(4'h0, 32'd0, "kick_disabled");
  endtask

  task automatic test_bad_kick();
    int e, ack;
    bus_write(4'h0, 32'd1, 4'h1, e);
    bus_write(4'h8, 32'h1234_5678, 4'hF, ack);
    bus_write(4'h8, KEY, 4'h1, ack);
    wait_bite(e, 21, "badkick");
    bus_read(4'h0, 32'd2, "badkick_cause");
    bus_write(4'h0, 32'd2, 4'h1, ack);
  endtask

  task automatic test_load_zero();
    int e, ack, bad_wdt;
    bus_write(4'h4, 32'd0, 4'hF, ack);
    bus_write(4'h0, 32'd1, 4'h1, e);
    wait_bite(e, 1, "load0");
    bus_read(4'h0, 32'd2, "load0_cause");
    bus_write(4'h0, 32'd2, 4'h1, ack);
    bus_read(4'h0, 32'd0, "load0_cause_clr");
    // Kick accepted exactly on the edge where COUNT sits at 0.
    bus_write(4'h4, 32'd3, 4'hF, ack);
    bus_write(4'h0, 32'd1, 4'h1, e);
    while (cyc < e + 3) @(negedge clk);
    bus_write(4'h8, KEY, 4'hF, ack);
    tests++;
    if (ack != e + 4) begin
      fails++;
      $display("FAIL kick_at_zero_timing: ack edge %0d, required %0d", ack - e, 4);
    end
    bus_write(4'h0, 32'd0, 4'h1, ack);
    bad_wdt = 0;
    for (int i = 0; i < 6; i++) begin
      if (wdt_reset_n !== 1'b1) bad_wdt++;
      @(negedge clk);
    end
    tests++;
    if (bad_wdt != 0) begin
      fails++;
      $display("FAIL kick_at_zero: %0d low samples, required 0", bad_wdt);
    end
    bus_read(4'h0, 32'd0, "kick_at_zero_ctrl");
  endtask

  task automatic test_reset_mid_fire();
    int e, ack;
    bus_write(4'h4, 32'd0, 4'hF, ack);
    bus_write(4'h0, 32'd1, 4'h1, e);
    repeat (4) @(negedge clk);
    tests++;
    if (wdt_reset_n !== 1'b0) begin
      fails++;
      $display("FAIL midfire_low: wdt=%b, required 0", wdt_reset_n);
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if (wdt_reset_n !== 1'b1) begin
      fails++;
      $display("FAIL midfire_async: wdt=%b, required 1", wdt_reset_n);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(4'h0, 32'd0, "post_reset_ctrl");
    bus_read(4'h4, 32'd8, "post_reset_load");
    bus_read(4'h8, 32'd0, "post_reset_kick");
    bus_read(4'hC, 32'd8, "post_reset_count");
    tests++;
    if (wdt_reset_n !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_wdt: %b, required 1", wdt_reset_n);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_bite();
    test_kick();
    test_bad_kick();
    test_load_zero();
    test_reset_mid_fire();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wdt_reset_req.md
# wdt_reset_req

Memory-mapped watchdog timer that produces an active-low reset request for the system reset chain. It sits on the picorv32 native memory bus as a word-addressed slave. Its `wdt_reset_n` output is ANDed into the `reset_button_n` input of the reset counter, so a missed kick restarts the CPU through the normal hold-off path. A sticky cause flag survives that restart, so firmware can tell a watchdog bite from a button press.

## Interface
- `PULSE_CYCLES`, default 16: width, in clk cycles, of the low pulse on `wdt_reset_n`. Must be at least 1.
- `KICK_KEY`, default 32'h5A5A_5A5A: value that must be written to KICK to reload the counter.
- `LOAD_RESET`, default 32'd27_000_000: reset value of LOAD and COUNT.
- `clk`, input, 1: system clock. The block has one clock.
- `reset_n`, input, 1: reset, asynchronous and active-low. Must come from the power-on/button domain upstream of the point where `wdt_reset_n` is merged, never from the post-watchdog reset.
- `mem_valid`, input, 1: bus request, qualified by the decoded chip select.
- `mem_ready`, output, 1: one-cycle acknowledge.
- `mem_addr`, input, 4: byte address. Only bits [3:2] are used.
- `mem_wstrb`, input, 4: byte write strobes. 0 means read.
- `mem_wdata`, input, 32: write data.
- `mem_rdata`, output, 32: read data, valid while `mem_ready` is high.
- `wdt_reset_n`, output, 1: active-low reset request.

## Operation
- Register map, indexed by `mem_addr[3:2]`:
  - 0, CTRL: bit0 EN (R/W). Bit1 CAUSE (read-only sticky; writing 1 clears it). Other bits read as 0.
  - 1, LOAD: 32-bit reload value. R/W with per-byte strobes.
  - 2, KICK: write-only. Reads return 0.
  - 3, COUNT: read-only current counter value.
- Reset values: `mem_ready`=0, `mem_rdata`=0, `wdt_reset_n`=1, EN=0, CAUSE=0, LOAD=LOAD_RESET, COUNT=LOAD_RESET, state IDLE.
- Write to CTRL: uses only byte lane 0 (`mem_wstrb[0]`).
- KICK write: counts only when `mem_wstrb`=4'hF and `mem_wdata`==KICK_KEY. It then sets COUNT to LOAD. Any other KICK write is ignored.
- LOAD writes never change COUNT directly. The new value takes effect at the next kick or enable.
- State IDLE:
  - EN=0 and COUNT holds.
  - A write that sets EN from 0 to 1 sets COUNT to LOAD (the new LOAD if written the same cycle is not possible; the registers are separate) and moves to RUN.
- State RUN:
  - COUNT decrements by 1 every cycle while COUNT is not 0.
  - If COUNT==0 and there is no valid kick this cycle, move to FIRE, set CAUSE=1 and clear EN.
  - A write setting EN=0 returns to IDLE and freezes COUNT.
  - A kick and COUNT==0 in the same cycle: the kick wins, COUNT=LOAD, and the block stays in RUN.
- State FIRE:
  - Drives `wdt_reset_n`=0 for exactly PULSE_CYCLES cycles, then returns to IDLE.
  - All bus writes during FIRE are acknowledged but do not change EN, COUNT or the pulse. A CAUSE clear is still honored.
- Arithmetic: COUNT is unsigned 32-bit with no wrap. It stops at 0. LOAD=0 fires on the first RUN cycle.

## Timing
- Bus handshake:
  - `mem_ready` rises one cycle after `mem_valid` is first seen and stays high for one cycle only.
  - Back-to-back `mem_valid` gives ready every other cycle.
  - The master holds address and data until ready.
  - A register update takes effect at the same edge that raises `mem_ready`.
- `mem_rdata` reflects register contents sampled at the request edge. It returns to 0 when `mem_ready` is low.
- Enable accepted at edge E with LOAD=N:
  - COUNT=N at E, and 0 at E+N.
  - `wdt_reset_n` falls at edge E+N+1.
  - `wdt_reset_n` rises at E+N+1+PULSE_CYCLES.
- `wdt_reset_n` is a registered output and glitch-free.
- Reset asserted mid-pulse forces `wdt_reset_n`=1 immediately (asynchronously) and clears CAUSE.

## Test plan
- Reset with LOAD_RESET=8: read all registers. Required: CTRL=0, LOAD=8, COUNT=8, `wdt_reset_n`=1, `mem_ready` pulses exactly one cycle per access.
- LOAD=5, then write CTRL=1 and never kick. Required: `wdt_reset_n` low starting 6 cycles after the enable ack edge, for 16 cycles. CTRL then reads 0x2.
- LOAD=20, enable, then kick with 0x5A5A5A5A every 10 cycles for 200 cycles. Required: no pulse. COUNT never reads below 10.
- Kick with a wrong key (0x12345678) and with `mem_wstrb`=4'h1. Required: both are ignored, and the bite happens on schedule.
- LOAD=0, enable. Required: fire at the next edge. Then write CTRL=0x2. Required: CAUSE clears. A kick landing in the same cycle as COUNT==0 must prevent the bite.
- Assert `reset_n` in the middle of FIRE. Required: `wdt_reset_n` returns to 1 asynchronously, and all registers read reset values afterward.
